// File: rtl/serial_tx.sv
// serial_tx: 8N1, LSB-first serial transmitter with a small byte FIFO.
// Bit timing comes from an internal divider of the osc clock.
module serial_tx #(
    parameter int unsigned CLKRATE  = 12_000_000,
    parameter int unsigned BAUDRATE = 9600,
    parameter int unsigned DEPTH    = 4
) (
    input  logic       osc,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned DIVISOR = CLKRATE / BAUDRATE;
    localparam int unsigned CW      = $clog2(DIVISOR);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned PW      = AW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;
    logic [7:0]    head;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_tick;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign ready = !full;
    assign push  = valid && !full;
    assign head  = mem[rd_ptr_q[AW-1:0]];
    assign busy  = (state_q != StIdle) || !empty;
    assign tx    = tx_q;

    assign baud_tick = (cnt_q == CW'(DIVISOR - 1));

    always_ff @(posedge osc) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StData: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (baud_tick) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when bytes are waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        bit_d   = '0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a line monitor decodes frames on the fast instance and
// checks them against bytes queued at acceptance; a default-rate instance checks bit timing.
module tb_serial_tx;

    localparam int DIV    = 4;
    localparam int DEFDIV = 1250;

    typedef struct {
        logic [7:0] b;
        bit         gap;
    } exp_t;

    logic       osc = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;
    logic       ready_a, tx_a, busy_a;
    logic       ready_b, tx_b, busy_b;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    serial_tx #(.CLKRATE(8), .BAUDRATE(2), .DEPTH(4)) dut_a (
        .osc(osc), .rst(rst), .data(data), .valid(valid_a),
        .ready(ready_a), .tx(tx_a), .busy(busy_a)
    );

    serial_tx dut_b (
        .osc(osc), .rst(rst), .data(data), .valid(valid_b),
        .ready(ready_b), .tx(tx_b), .busy(busy_b)
    );

    initial forever #5 osc = ~osc;
    initial forever begin
        @(posedge osc);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line monitor: every low level seen on an idle line starts a frame that must match
    // the head of the scoreboard, cycle by cycle.
    initial begin
        int         pos = -1;
        int         last_end = -100;
        bit         bad = 0;
        bit         unexp = 0;
        logic [9:0] frame = '0;
        logic [9:0] got = '0;
        exp_t       e;
        forever begin
            @(negedge osc);
            if (rst) begin
                pos = -1;
            end else begin
                if (pos < 0 && tx_a === 1'b0) begin
                    pos = 0;
                    bad = 0;
                    got = '0;
                    if (exp_q.size() == 0) begin
                        unexp = 1;
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: line low at cycle %0d, required idle", cyc);
                    end else begin
                        unexp = 0;
                        e = exp_q.pop_front();
                        frame = {1'b1, e.b, 1'b0};
                        if (e.gap) begin
                            tests++;
                            if (cyc != last_end + 1) begin
                                fails++;
                                $display("FAIL frame_gap: start at cycle %0d, required %0d",
                                         cyc, last_end + 1);
                            end
                        end
                    end
                end
                if (pos >= 0) begin
                    if (!unexp && tx_a !== frame[pos / DIV]) bad = 1;
                    if (pos % DIV == DIV / 2) got[pos / DIV] = tx_a;
                    pos++;
                    if (pos == 10 * DIV) begin
                        pos = -1;
                        last_end = cyc;
                        if (!unexp) begin
                            tests++;
                            if (bad) begin
                                fails++;
                                $display("FAIL frame: got line bits %b, required %b", got, frame);
                            end
                        end
                    end
                end
            end
        end
    end

    // Holds valid high until the byte is taken; acc is the accepting edge number.
    task automatic push_a(input logic [7:0] b, input bit gap, output int acc);
        int n = 0;
        @(negedge osc);
        data    = b;
        valid_a = 1'b1;
        while (!ready_a && n < 200) begin
            @(negedge osc);
            n++;
        end
        check("push_accept", 32'(ready_a), 32'd1);
        acc = cyc + 1;
        if (ready_a) exp_q.push_back('{b: b, gap: gap});
    endtask

    task automatic wait_idle_a(input int bound);
        int n = 0;
        while (busy_a && n < bound) begin
            @(negedge osc);
            n++;
        end
        check("drain_idle", 32'(busy_a), 32'd0);
    endtask

    initial begin
        int         acc, acc1, acc5, acc6, e0, n, lows, busys;
        int         t0;
        int         match[10];
        logic [9:0] frame_b;

        // Power-on reset.
        @(negedge osc);
        @(negedge osc);
        check("por_tx", 32'(tx_a), 32'd1);
        check("por_ready", 32'(ready_a), 32'd1);
        check("por_busy", 32'(busy_a), 32'd0);
        check("por_tx_b", 32'(tx_b), 32'd1);
        rst = 1'b0;

        // Single byte: latency, line bits (monitor) and busy release.
        push_a(8'hA5, 1'b0, acc);
        @(negedge osc);
        valid_a = 1'b0;
        check("accept_busy", 32'(busy_a), 32'd1);
        check("accept_tx_idle", 32'(tx_a), 32'd1);
        @(negedge osc);
        check("start_latency", 32'(tx_a), 32'd0);
        n = 0;
        while (busy_a && n < 200) begin
            @(negedge osc);
            n++;
        end
        check("busy_drop_cycle", 32'(cyc), 32'(acc + 41));

        // Reset while idle: outputs forced and held.
        @(negedge osc);
        rst = 1'b1;
        #1;
        check("idle_rst_tx", 32'(tx_a), 32'd1);
        check("idle_rst_ready", 32'(ready_a), 32'd1);
        check("idle_rst_busy", 32'(busy_a), 32'd0);
        @(negedge osc);
        check("idle_rst_hold_tx", 32'(tx_a), 32'd1);
        check("idle_rst_hold_ready", 32'(ready_a), 32'd1);
        rst = 1'b0;

        // Burst of six with valid held: five fit, the sixth waits for the second pop.
        push_a(8'h01, 1'b0, acc1);
        push_a(8'h02, 1'b1, acc);
        push_a(8'h03, 1'b1, acc);
        push_a(8'h04, 1'b1, acc);
        push_a(8'h05, 1'b1, acc5);
        check("burst_acc5_cycle", 32'(acc5), 32'(acc1 + 4));
        @(negedge osc);
        check("burst_full_ready", 32'(ready_a), 32'd0);
        push_a(8'h06, 1'b1, acc6);
        check("burst_ready_return", 32'(acc6), 32'(acc1 + 42));
        @(negedge osc);
        valid_a = 1'b0;
        wait_idle_a(400);
        check("burst_all_sent", 32'(exp_q.size()), 32'd0);

        // Overflow: a byte offered while full must vanish.
        push_a(8'h10, 1'b0, acc);
        push_a(8'h11, 1'b1, acc);
        push_a(8'h12, 1'b1, acc);
        push_a(8'h13, 1'b1, acc);
        push_a(8'h14, 1'b1, acc);
        @(negedge osc);
        data = 8'hFF;
        check("ovf_ready_low", 32'(ready_a), 32'd0);
        repeat (3) @(negedge osc);
        check("ovf_ready_still_low", 32'(ready_a), 32'd0);
        valid_a = 1'b0;
        wait_idle_a(400);
        check("ovf_all_sent", 32'(exp_q.size()), 32'd0);

        // Reset during d3 of 0x00 with two bytes queued.
        push_a(8'h00, 1'b0, acc);
        e0 = acc + 1;
        push_a(8'h11, 1'b1, acc);
        push_a(8'h22, 1'b1, acc);
        @(negedge osc);
        valid_a = 1'b0;
        while (cyc < e0 + 17) @(negedge osc);
        check("d3_line_low", 32'(tx_a), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midframe_rst_tx", 32'(tx_a), 32'd1);
        check("midframe_rst_ready", 32'(ready_a), 32'd1);
        check("midframe_rst_busy", 32'(busy_a), 32'd0);
        @(negedge osc);
        @(negedge osc);
        rst = 1'b0;
        lows = 0;
        busys = 0;
        repeat (100) begin
            @(negedge osc);
            if (tx_a !== 1'b1) lows++;
            if (busy_a !== 1'b0) busys++;
        end
        check("post_rst_line_idle", 32'(lows), 32'd0);
        check("post_rst_not_busy", 32'(busys), 32'd0);

        // Default parameters: 0x55 with 1250-cycle bits, 12500-cycle frame.
        frame_b = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 10; k++) match[k] = 0;
        @(negedge osc);
        data    = 8'h55;
        valid_b = 1'b1;
        check("def_ready", 32'(ready_b), 32'd1);
        @(negedge osc);
        valid_b = 1'b0;
        n = 0;
        while (tx_b !== 1'b0 && n < 10) begin
            @(negedge osc);
            n++;
        end
        check("def_start", 32'(tx_b), 32'd0);
        t0 = cyc;
        for (int i = 0; i < 10 * DEFDIV; i++) begin
            if (tx_b === frame_b[i / DEFDIV]) match[i / DEFDIV]++;
            if (i == 10 * DEFDIV - 1) check("def_busy_in_stop", 32'(busy_b), 32'd1);
            @(negedge osc);
        end
        check("def_frame_end_cycle", 32'(cyc), 32'(t0 + 10 * DEFDIV));
        check("def_busy_after_frame", 32'(busy_b), 32'd0);
        check("def_tx_after_frame", 32'(tx_b), 32'd1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("def_bit%0d_cycles", k), 32'(match[k]), 32'(DEFDIV));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
